// File: rtl/core_pkg.sv
// Shared pipeline definitions: MEM-stage FSM states, WB mux select encodings
// and the default datapath width.
package core_pkg;

    localparam int unsigned XLEN_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_PC4  = 2'b10;
    localparam logic [1:0] RES_IMM  = 2'b11;

endpackage

// File: rtl/stage_memory_if.sv
// Data-memory req/ack port. The MEM stage is the master and the memory is the slave.
interface stage_memory_if
    import core_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
);

    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/stage_memory_dmem_if_ctrl.sv
// Data-memory transaction controller: IDLE/BUSY/DONE sequencing, ack timeout,
// registered request fields, load data latch and the pipeline stall.
module dmem_if_ctrl
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned XLEN           = XLEN_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_mem_read,
    input  logic                 mem_mem_write,
    input  logic [XLEN-1:0]      mem_alu_result,
    input  logic [XLEN-1:0]      mem_write_data,
    stage_memory_if.master       dmem,
    output logic                 mem_stall,
    output logic                 mem_fault,
    output mem_state_t           state,
    output logic                 abort,
    output logic [XLEN-1:0]      load_data
);

    localparam int unsigned   CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    mem_state_t    state_q;
    mem_state_t    state_d;
    logic [CW-1:0] cnt;
    logic          access;

    assign access = mem_mem_read | mem_mem_write;
    assign state  = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    mem_stall = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                if (dmem.ack || cnt == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields stay frozen through BUSY; a store never touches the load latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dmem.req   <= 1'b0;
            dmem.we    <= 1'b0;
            dmem.addr  <= '0;
            dmem.wdata <= '0;
            cnt        <= '0;
            mem_fault  <= 1'b0;
            abort      <= 1'b0;
            load_data  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access) begin
                        dmem.req   <= 1'b1;
                        dmem.we    <= mem_mem_write;
                        dmem.addr  <= {mem_alu_result[XLEN-1:2], 2'b00};
                        dmem.wdata <= mem_write_data;
                        cnt        <= '0;
                    end
                end
                BUSY: begin
                    if (dmem.ack) begin
                        dmem.req <= 1'b0;
                        if (!dmem.we) begin
                            load_data <= dmem.rdata;
                        end
                    end else if (cnt == CNT_LAST) begin
                        dmem.req  <= 1'b0;
                        mem_fault <= 1'b1;
                        abort     <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE:    abort <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/stage_memory.sv
// Pipeline MEM stage: word loads/stores over a req/ack port and the MEM/WB
// pipeline register. Non-memory instructions pass through in one cycle.
module stage_memory
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned XLEN           = XLEN_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      mem_instr,
    input  logic             mem_reg_write,
    input  logic             mem_mem_write,
    input  logic             mem_mem_read,
    input  logic [1:0]       mem_result_src,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic [XLEN-1:0]  mem_write_data,
    input  logic [XLEN-1:0]  mem_pc_plus_4,
    input  logic [XLEN-1:0]  mem_imm_ext,
    input  logic [4:0]       mem_rd,
    stage_memory_if.master   dmem,
    output logic             mem_stall,
    output logic             mem_fault,
    output logic [31:0]      wb_instr,
    output logic             wb_reg_write,
    output logic [1:0]       wb_result_src,
    output logic [XLEN-1:0]  wb_alu_result,
    output logic [XLEN-1:0]  wb_read_data,
    output logic [XLEN-1:0]  wb_pc_plus_4,
    output logic [XLEN-1:0]  wb_imm_ext,
    output logic [4:0]       wb_rd
);

    mem_state_t      ctrl_state;
    logic            abort;
    logic [XLEN-1:0] load_data;
    logic            access;

    assign access = mem_mem_read | mem_mem_write;

    dmem_if_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .XLEN           (XLEN)
    ) u_ctrl (
        .clk            (clk),
        .reset          (reset),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .mem_alu_result (mem_alu_result),
        .mem_write_data (mem_write_data),
        .dmem           (dmem),
        .mem_stall      (mem_stall),
        .mem_fault      (mem_fault),
        .state          (ctrl_state),
        .abort          (abort),
        .load_data      (load_data)
    );

    // While a transaction is in flight WB sees a bubble; other fields hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_instr      <= '0;
            wb_reg_write  <= 1'b0;
            wb_result_src <= '0;
            wb_alu_result <= '0;
            wb_read_data  <= '0;
            wb_pc_plus_4  <= '0;
            wb_imm_ext    <= '0;
            wb_rd         <= '0;
        end else begin
            case (ctrl_state)
                IDLE: begin
                    if (access) begin
                        wb_reg_write <= 1'b0;
                    end else begin
                        wb_instr      <= mem_instr;
                        wb_reg_write  <= mem_reg_write;
                        wb_result_src <= mem_result_src;
                        wb_alu_result <= mem_alu_result;
                        wb_read_data  <= '0;
                        wb_pc_plus_4  <= mem_pc_plus_4;
                        wb_imm_ext    <= mem_imm_ext;
                        wb_rd         <= mem_rd;
                    end
                end
                BUSY: wb_reg_write <= 1'b0;
                DONE: begin
                    wb_instr      <= mem_instr;
                    wb_reg_write  <= mem_reg_write & ~abort;
                    wb_result_src <= mem_result_src;
                    wb_alu_result <= mem_alu_result;
                    wb_read_data  <= abort ? '0 : load_data;
                    wb_pc_plus_4  <= mem_pc_plus_4;
                    wb_imm_ext    <= mem_imm_ext;
                    wb_rd         <= mem_rd;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// Self-checking bench for stage_memory: acts as hazard unit and data memory,
// comparing against a transaction-level model of the MEM stage.
module tb_stage_memory;
    import core_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] mem_instr;
    logic        mem_reg_write, mem_mem_write, mem_mem_read;
    logic [1:0]  mem_result_src;
    logic [31:0] mem_alu_result, mem_write_data, mem_pc_plus_4, mem_imm_ext;
    logic [4:0]  mem_rd;
    logic        mem_stall, mem_fault;
    logic [31:0] wb_instr;
    logic        wb_reg_write;
    logic [1:0]  wb_result_src;
    logic [31:0] wb_alu_result, wb_read_data, wb_pc_plus_4, wb_imm_ext;
    logic [4:0]  wb_rd;

    stage_memory_if #(.XLEN(32)) dmem_bus ();

    always #5 clk = ~clk;

    stage_memory #(
        .TIMEOUT_CYCLES (TO),
        .XLEN           (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_instr      (mem_instr),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_write  (mem_mem_write),
        .mem_mem_read   (mem_mem_read),
        .mem_result_src (mem_result_src),
        .mem_alu_result (mem_alu_result),
        .mem_write_data (mem_write_data),
        .mem_pc_plus_4  (mem_pc_plus_4),
        .mem_imm_ext    (mem_imm_ext),
        .mem_rd         (mem_rd),
        .dmem           (dmem_bus),
        .mem_stall      (mem_stall),
        .mem_fault      (mem_fault),
        .wb_instr       (wb_instr),
        .wb_reg_write   (wb_reg_write),
        .wb_result_src  (wb_result_src),
        .wb_alu_result  (wb_alu_result),
        .wb_read_data   (wb_read_data),
        .wb_pc_plus_4   (wb_pc_plus_4),
        .wb_imm_ext     (wb_imm_ext),
        .wb_rd          (wb_rd)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: word memory, the load latch and the sticky fault.
    logic [31:0] mem_m [logic [31:0]];
    logic [31:0] latch_m;
    logic        fault_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // Present one instruction in MEM (called just after a posedge) and serve it.
    // k = ack delay in BUSY cycles; k < 0 means the memory never answers.
    task automatic run_op(input logic rw, input logic mw, input logic mrd,
                          input logic [1:0] src, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [31:0] pc4,
                          input logic [31:0] imm, input logic [4:0] rd, input int k);
        logic        access, abort_e, done;
        logic [31:0] addr, instr;
        int          stalls, req_hi, exp_stalls, exp_reqhi;
        access  = mw | mrd;
        abort_e = access && (k < 0 || k >= TO);
        addr    = alu & ~32'h3;
        instr   = $urandom;
        mem_instr = instr;      mem_reg_write = rw;   mem_mem_write = mw;
        mem_mem_read = mrd;     mem_result_src = src; mem_alu_result = alu;
        mem_write_data = wd;    mem_pc_plus_4 = pc4;  mem_imm_ext = imm;
        mem_rd = rd;
        dmem_bus.ack = 1'b0;
        exp_stalls = !access ? 0 : abort_e ? TO + 1 : k + 2;
        exp_reqhi  = !access ? 0 : abort_e ? TO : k + 1;
        stalls = 0; req_hi = 0; done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            dmem_bus.ack = 1'b0;
            if (mem_stall) stalls++; else done = 1'b1;
            if (dmem_bus.req) begin
                check("req_addr", dmem_bus.addr, addr);
                check("req_we", dmem_bus.we, mw);
                if (mw) check("req_wdata", dmem_bus.wdata, wd);
                check("busy_wb_reg_write", wb_reg_write, 0);
                if (req_hi == k) begin
                    dmem_bus.ack = 1'b1;
                    if (mw) mem_m[addr] = wd;
                    else begin
                        dmem_bus.rdata = mem_val(addr);
                        latch_m = dmem_bus.rdata;
                    end
                end
                req_hi++;
            end
        end
        if (!done) check("stall_bound", 1, 0);
        @(posedge clk);
        #1;
        dmem_bus.ack = 1'b0;
        if (abort_e) fault_m = 1'b1;
        check("stall_cycles", stalls, exp_stalls);
        check("req_cycles", req_hi, exp_reqhi);
        check("wb_instr", wb_instr, instr);
        check("wb_reg_write", wb_reg_write, rw & ~abort_e);
        check("wb_result_src", wb_result_src, src);
        check("wb_alu_result", wb_alu_result, alu);
        check("wb_read_data", wb_read_data, (!access || abort_e) ? 32'h0 : latch_m);
        check("wb_pc_plus_4", wb_pc_plus_4, pc4);
        check("wb_imm_ext", wb_imm_ext, imm);
        check("wb_rd", wb_rd, rd);
        check("mem_fault", mem_fault, fault_m);
    endtask

    initial begin
        int kind, k;
        mem_instr = '0; mem_reg_write = 0; mem_mem_write = 0; mem_mem_read = 0;
        mem_result_src = '0; mem_alu_result = '0; mem_write_data = '0;
        mem_pc_plus_4 = '0; mem_imm_ext = '0; mem_rd = '0;
        dmem_bus.ack = 1'b0; dmem_bus.rdata = '0;
        latch_m = '0; fault_m = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_req", dmem_bus.req, 0);
        check("rst_we", dmem_bus.we, 0);
        check("rst_addr", dmem_bus.addr, 0);
        check("rst_wdata", dmem_bus.wdata, 0);
        check("rst_fault", mem_fault, 0);
        check("rst_stall", mem_stall, 0);
        check("rst_wb_reg_write", wb_reg_write, 0);
        check("rst_wb_alu_result", wb_alu_result, 0);
        check("rst_wb_read_data", wb_read_data, 0);
        check("rst_wb_rd", wb_rd, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        run_op(1, 0, 0, RES_ALU, 32'h1234, 32'h0, 32'h8, 32'h0, 5'd5, 0);
        mem_m[32'h100] = 32'hDEADBEEF;
        run_op(1, 0, 1, RES_LOAD, 32'h103, 32'h0, 32'h10, 32'h0, 5'd6, 3);
        run_op(0, 1, 0, RES_ALU, 32'h200, 32'hCAFE, 32'h14, 32'h0, 5'd0, 0);
        mem_m[32'h10] = 32'h1111_0010;
        mem_m[32'h14] = 32'h2222_0014;
        run_op(1, 0, 1, RES_LOAD, 32'h10, 32'h0, 32'h18, 32'h0, 5'd7, 1);
        run_op(1, 0, 1, RES_LOAD, 32'h14, 32'h0, 32'h1C, 32'h0, 5'd8, 1);
        run_op(1, 0, 1, RES_LOAD, 32'h202, 32'h0, 32'h20, 32'h0, 5'd9, 2);
        run_op(1, 0, 1, RES_LOAD, 32'h300, 32'h0, 32'h24, 32'h0, 5'd10, -1);
        run_op(1, 0, 0, RES_IMM, 32'h55, 32'h0, 32'h28, 32'hABCD, 5'd11, 0);
        run_op(1, 1, 1, RES_LOAD, 32'h30, 32'h77, 32'h2C, 32'h0, 5'd12, 2);

        // Randomized mix; small address window so loads revisit stored words
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            k    = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 3);
            run_op(1'($urandom), kind == 2 || kind == 3, kind == 1 || kind == 3,
                   2'($urandom), 32'($urandom_range(0, 63)), $urandom,
                   $urandom, $urandom, 5'($urandom), k);
        end

        // Asynchronous reset in the middle of BUSY
        mem_reg_write = 1; mem_mem_read = 1; mem_mem_write = 0;
        mem_alu_result = 32'h40; mem_rd = 5'd3;
        repeat (3) @(negedge clk);
        check("pre_rst_req", dmem_bus.req, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_req", dmem_bus.req, 0);
        check("arst_fault", mem_fault, 0);
        check("arst_wb_reg_write", wb_reg_write, 0);
        check("arst_wb_instr", wb_instr, 0);
        check("arst_wb_alu_result", wb_alu_result, 0);
        check("arst_wb_read_data", wb_read_data, 0);
        check("arst_wb_rd", wb_rd, 0);
        fault_m = 1'b0;
        latch_m = '0;
        mem_mem_read = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        run_op(1, 0, 0, RES_PC4, 32'h99, 32'h0, 32'h44, 32'h0, 5'd13, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
